// File: rtl/cache_refill_arbiter_if.sv
// cache_refill_arbiter_if: requester, memory and response signals of the refill arbiter
interface cache_refill_arbiter_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    logic              req0_valid;
    logic              req1_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [ADDR_W-1:0] req1_addr;
    logic              req0_ready;
    logic              req1_ready;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              resp_valid;
    logic              resp_id;
    logic [IDX_W-1:0]  resp_word;
    logic [DATA_W-1:0] resp_data;
    logic              resp_last;
    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr, mem_ready, mem_rdata,
        output req0_ready, req1_ready, mem_req, mem_addr,
        output resp_valid, resp_id, resp_word, resp_data, resp_last
    );
    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr, mem_ready, mem_rdata,
        input  req0_ready, req1_ready, mem_req, mem_addr,
        input  resp_valid, resp_id, resp_word, resp_data, resp_last
    );
endinterface

// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter: per-line demand/prefetch arbitration with critical-word-first wrapping bursts
module cache_refill_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LINE_WORDS   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input logic clk,
    input logic rst,
    cache_refill_arbiter_if.slave bus
);
    localparam int BYTE_W = $clog2(DATA_W / 8);
    localparam int IDX_W  = $clog2(LINE_WORDS);
    localparam int LB_W   = ADDR_W - IDX_W - BYTE_W;
    localparam int SK_W   = $clog2(STARVE_LIMIT + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t            state_q, state_d;
    logic [LB_W-1:0]   line_base_q, line_base_d;
    logic [IDX_W-1:0]  start_idx_q, start_idx_d;
    logic [IDX_W-1:0]  beat_q, beat_d;
    logic              owner_q, owner_d;
    logic [SK_W-1:0]   skip_q, skip_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;
    logic [IDX_W-1:0]  resp_word_q, resp_word_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_last_q, resp_last_d;
    logic              pick1, grant0, grant1, grant, beat_done, beat_last;
    logic [IDX_W-1:0]  beat_idx;
    logic [ADDR_W-1:0] win_addr;
    always_comb begin
        // Prefetch only wins a contested cycle once demand has starved it STARVE_LIMIT times
        pick1       = bus.req1_valid && (!bus.req0_valid || skip_q == SK_W'(STARVE_LIMIT));
        grant0      = rst && state_q == IDLE && bus.req0_valid && !pick1;
        grant1      = rst && state_q == IDLE && pick1;
        grant       = grant0 || grant1;
        beat_idx    = start_idx_q + beat_q;
        beat_done   = state_q == BURST && bus.mem_ready;
        beat_last   = beat_done && beat_q == IDX_W'(LINE_WORDS - 1);
        win_addr    = grant1 ? bus.req1_addr : bus.req0_addr;
        state_d     = grant ? BURST : beat_last ? IDLE : state_q;
        line_base_d = grant ? win_addr[ADDR_W-1:IDX_W+BYTE_W] : line_base_q;
        start_idx_d = grant ? win_addr[IDX_W+BYTE_W-1:BYTE_W] : start_idx_q;
        owner_d     = grant ? grant1 : owner_q;
        beat_d      = grant ? '0 : beat_done ? beat_q + IDX_W'(1) : beat_q;
        skip_d      = grant1 ? '0 :
                      (grant0 && bus.req1_valid && skip_q != SK_W'(STARVE_LIMIT)) ? skip_q + SK_W'(1) : skip_q;
        resp_valid_d = beat_done;
        resp_id_d    = beat_done && owner_q;
        resp_word_d  = beat_done ? beat_idx : '0;
        resp_data_d  = beat_done ? bus.mem_rdata : '0;
        resp_last_d  = beat_last;
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        bus.mem_req    = state_q == BURST;
        bus.mem_addr   = state_q == BURST ? ADDR_W'({line_base_q, beat_idx}) << BYTE_W : '0;
        bus.resp_valid = resp_valid_q;
        bus.resp_id    = resp_id_q;
        bus.resp_word  = resp_word_q;
        bus.resp_data  = resp_data_q;
        bus.resp_last  = resp_last_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            line_base_q  <= '0;
            start_idx_q  <= '0;
            beat_q       <= '0;
            owner_q      <= 1'b0;
            skip_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_word_q  <= '0;
            resp_data_q  <= '0;
            resp_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_base_q  <= line_base_d;
            start_idx_q  <= start_idx_d;
            beat_q       <= beat_d;
            owner_q      <= owner_d;
            skip_q       <= skip_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_word_q  <= resp_word_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
        end
    end
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// tb_cache_refill_arbiter: directed self-checking bench for cache_refill_arbiter
module tb_cache_refill_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    cache_refill_arbiter_if u_if ();
    cache_refill_arbiter dut (.clk(clk), .rst(rst), .bus(u_if));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // One zero-wait line: grant in the current cycle, four beats, then the final response cycle
    task automatic line_zw(input bit sel, input logic [31:0] addr, input logic [127:0] ea, input logic [7:0] ew);
        if (sel) begin
            u_if.req1_valid = 1'b1;
            u_if.req1_addr  = addr;
        end else begin
            u_if.req0_valid = 1'b1;
            u_if.req0_addr  = addr;
        end
        #1;
        chk("zw_grant_r0", 64'(u_if.req0_ready), 64'(!sel));
        chk("zw_grant_r1", 64'(u_if.req1_ready), 64'(sel));
        for (int k = 0; k < 4; k++) begin
            tick;
            u_if.req0_valid = 1'b0;
            u_if.req1_valid = 1'b0;
            u_if.mem_ready  = 1'b1;
            u_if.mem_rdata  = 32'hC0DE_0000 + k;
            #1;
            chk("zw_mem_req", 64'(u_if.mem_req), 64'd1);
            chk("zw_mem_addr", 64'(u_if.mem_addr), 64'(ea[k*32+:32]));
            chk("zw_busy_r0", 64'(u_if.req0_ready), 64'd0);
            if (k > 0) begin
                chk("zw_resp_valid", 64'(u_if.resp_valid), 64'd1);
                chk("zw_resp_id", 64'(u_if.resp_id), 64'(sel));
                chk("zw_resp_word", 64'(u_if.resp_word), 64'(ew[(k-1)*2+:2]));
                chk("zw_resp_data", 64'(u_if.resp_data), 64'(32'hC0DE_0000 + k - 1));
                chk("zw_resp_last", 64'(u_if.resp_last), 64'd0);
            end
        end
        tick;
        u_if.mem_ready = 1'b0;
        #1;
        chk("zw_end_mem_req", 64'(u_if.mem_req), 64'd0);
        chk("zw_end_valid", 64'(u_if.resp_valid), 64'd1);
        chk("zw_end_id", 64'(u_if.resp_id), 64'(sel));
        chk("zw_end_word", 64'(u_if.resp_word), 64'(ew[6+:2]));
        chk("zw_end_data", 64'(u_if.resp_data), 64'h0000_0000_C0DE_0003);
        chk("zw_end_last", 64'(u_if.resp_last), 64'd1);
    endtask
    logic [31:0] wa [4];
    logic [5:0]  pf;
    int b, resps, lasts;
    logic prev_ready;
    initial begin
        u_if.req0_valid = 1'b0;
        u_if.req1_valid = 1'b0;
        u_if.req0_addr  = '0;
        u_if.req1_addr  = '0;
        u_if.mem_ready  = 1'b0;
        u_if.mem_rdata  = '0;
        repeat (2) tick;
        u_if.req0_valid = 1'b1;
        #1;
        chk("rst_mem_req", 64'(u_if.mem_req), 64'd0);
        chk("rst_mem_addr", 64'(u_if.mem_addr), 64'd0);
        chk("rst_r0", 64'(u_if.req0_ready), 64'd0);
        chk("rst_resp_valid", 64'(u_if.resp_valid), 64'd0);
        chk("rst_resp_data", 64'(u_if.resp_data), 64'd0);
        u_if.req0_valid = 1'b0;
        rst = 1'b1;
        tick;
        // Single demand miss, critical word 2
        line_zw(1'b0, 32'h0000_1008, {32'h1004, 32'h1000, 32'h100C, 32'h1008}, {2'd1, 2'd0, 2'd3, 2'd2});
        // Wait-state memory: ready every third cycle
        wa[0] = 32'h3000; wa[1] = 32'h3004; wa[2] = 32'h3008; wa[3] = 32'h300C;
        u_if.req0_valid = 1'b1;
        u_if.req0_addr  = 32'h3000;
        #1;
        chk("ws_grant", 64'(u_if.req0_ready), 64'd1);
        b = 0; resps = 0; lasts = 0; prev_ready = 1'b0;
        for (int c = 0; c < 30 && b < 4; c++) begin
            tick;
            u_if.req0_valid = 1'b0;
            chk("ws_resp_follows_ready", 64'(u_if.resp_valid), 64'(prev_ready));
            resps += int'(u_if.resp_valid);
            lasts += int'(u_if.resp_last);
            u_if.mem_ready = (c % 3 == 2);
            #1;
            chk("ws_mem_req", 64'(u_if.mem_req), 64'd1);
            chk("ws_mem_addr", 64'(u_if.mem_addr), 64'(wa[b]));
            prev_ready = u_if.mem_ready;
            if (u_if.mem_ready) b++;
        end
        chk("ws_beats", 64'(b), 64'd4);
        tick;
        u_if.mem_ready = 1'b0;
        resps += int'(u_if.resp_valid);
        lasts += int'(u_if.resp_last);
        #1;
        chk("ws_end_last", 64'(u_if.resp_last), 64'd1);
        chk("ws_end_mem_req", 64'(u_if.mem_req), 64'd0);
        chk("ws_resp_count", 64'(resps), 64'd4);
        chk("ws_last_count", 64'(lasts), 64'd1);
        // Contested requests: prefetch wins the fourth line, then demand again
        pf = 6'b001000;
        u_if.req0_valid = 1'b1;
        u_if.req0_addr  = 32'h4000;
        u_if.req1_valid = 1'b1;
        u_if.req1_addr  = 32'h5000;
        for (int g = 0; g < 6; g++) begin
            #1;
            chk("starve_r0", 64'(u_if.req0_ready), 64'(!pf[g]));
            chk("starve_r1", 64'(u_if.req1_ready), 64'(pf[g]));
            for (int k = 0; k < 4; k++) begin
                tick;
                u_if.mem_ready = 1'b1;
                #1;
                chk("starve_busy_r0", 64'(u_if.req0_ready), 64'd0);
                chk("starve_busy_r1", 64'(u_if.req1_ready), 64'd0);
            end
            tick;
            u_if.mem_ready = 1'b0;
        end
        // Seventh line saturates skip_cnt; reset during beat 2 must clear it
        #1;
        chk("starve_g6_r0", 64'(u_if.req0_ready), 64'd1);
        tick;
        u_if.mem_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
        chk("mid_rst_mem_req", 64'(u_if.mem_req), 64'd0);
        chk("mid_rst_mem_addr", 64'(u_if.mem_addr), 64'd0);
        chk("mid_rst_resp_valid", 64'(u_if.resp_valid), 64'd0);
        chk("mid_rst_resp_word", 64'(u_if.resp_word), 64'd0);
        chk("mid_rst_resp_data", 64'(u_if.resp_data), 64'd0);
        chk("mid_rst_resp_last", 64'(u_if.resp_last), 64'd0);
        chk("mid_rst_r0", 64'(u_if.req0_ready), 64'd0);
        chk("mid_rst_r1", 64'(u_if.req1_ready), 64'd0);
        tick;
        rst = 1'b1;
        #1;
        chk("post_rst_resp_valid", 64'(u_if.resp_valid), 64'd0);
        chk("post_rst_skip_r0", 64'(u_if.req0_ready), 64'd1);
        chk("post_rst_skip_r1", 64'(u_if.req1_ready), 64'd0);
        u_if.req0_valid = 1'b0;
        #1;
        chk("post_rst_pf_grant", 64'(u_if.req1_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            tick;
            u_if.req1_valid = 1'b0;
            u_if.mem_ready  = 1'b1;
        end
        tick;
        u_if.mem_ready = 1'b0;
        #1;
        chk("post_rst_last", 64'(u_if.resp_last), 64'd1);
        chk("post_rst_id", 64'(u_if.resp_id), 64'd1);
        // Prefetch alone, wrapping from the last word
        line_zw(1'b1, 32'h0000_2FFC, {32'h2FF8, 32'h2FF4, 32'h2FF0, 32'h2FFC}, {2'd2, 2'd1, 2'd0, 2'd3});
        // Spurious mem_ready in IDLE
        for (int k = 0; k < 3; k++) begin
            tick;
            u_if.mem_ready = 1'b1;
            #1;
            chk("spur_mem_req", 64'(u_if.mem_req), 64'd0);
            chk("spur_resp_valid", 64'(u_if.resp_valid), 64'd0);
        end
        tick;
        u_if.mem_ready = 1'b0;
        #1;
        chk("spur_resp_after", 64'(u_if.resp_valid), 64'd0);
        u_if.req0_valid = 1'b1;
        u_if.req0_addr  = 32'h0;
        #1;
        chk("spur_still_idle", 64'(u_if.req0_ready), 64'd1);
        u_if.req0_valid = 1'b0;
        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
